// File: rtl/rv32_soc_top.sv
// rtl/rv32_soc_top.sv - 5-stage RV32I pipelined core with instruction ROM and data RAM
//
// rv32_soc_top : simulation/synthesis root; clk, rst_n (sync, active-low) only.
// rv32_rom     : 1024 x 32 combinational-read ROM; i_addr word index, o_data.
// rv32_ram     : 2048 x 32 RAM; combinational read when i_ce, byte-lane write on i_ce & i_we.
// rv32_regfile : 32 x 32, two read ports with write-through, one write port, x0 hardwired to 0.
// rv32_core    : IF/ID/EX/MEM/WB pipeline; ROM fetch port, RAM load/store port.

module rv32_rom (
    input  logic [9:0]  i_addr,
    output logic [31:0] o_data
);
    logic [31:0] rom_mem [0:1023];
    assign o_data = rom_mem[i_addr];
endmodule

module rv32_ram (
    input  logic        i_clk,
    input  logic        i_ce,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    input  logic [10:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] ram_mem [0:2047];

    always_ff @(posedge i_clk) begin
        if (i_ce && i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_sel[b]) ram_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = i_ce ? ram_mem[i_addr] : 32'h0;
endmodule

module rv32_regfile (
    input  logic        i_clk,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);
    logic [31:0] regfile [0:31];

    always_ff @(posedge i_clk) begin
        if (i_we && i_wa != 5'd0) regfile[i_wa] <= i_wd;
    end

    // WB writes and ID reads in the same cycle: hand the new value straight through.
    assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : (i_we && i_wa == i_ra1) ? i_wd : regfile[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : (i_we && i_wa == i_ra2) ? i_wd : regfile[i_ra2];
endmodule

module rv32_core (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_rom_addr,
    input  logic [31:0] i_rom_data,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_wdata,
    input  logic [31:0] i_ram_rdata,
    output logic [3:0]  o_ram_sel,
    output logic        o_ram_ce,
    output logic        o_ram_we
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] if_pc;
    logic        r_halt;
    logic [31:0] r_id_instr, r_id_pc;
    logic [31:0] r_ex_pc, r_ex_a, r_ex_b, r_ex_imm;
    logic [4:0]  r_ex_rs1, r_ex_rs2, r_ex_rd;
    logic [2:0]  r_ex_f3;
    logic        r_ex_alt, r_ex_a_pc, r_ex_a_zero, r_ex_b_imm, r_ex_we, r_ex_ld, r_ex_st;
    logic [31:0] r_mem_res, r_mem_sd;
    logic [4:0]  r_mem_rd;
    logic        r_mem_we, r_mem_ld, r_mem_st;
    logic [31:0] r_wb_res;
    logic [4:0]  r_wb_rd;
    logic        r_wb_we;

    // ---------------- ID: decode ----------------
    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_u, w_rd1, w_rd2, w_imm;
    logic [2:0]  w_dec_f3;
    logic        w_we, w_ld, w_st, w_alt, w_a_pc, w_a_zero, w_b_imm, w_use1, w_use2, w_dec_halt;
    logic        w_stall;

    assign w_op    = r_id_instr[6:0];
    assign w_rd    = r_id_instr[11:7];
    assign w_f3    = r_id_instr[14:12];
    assign w_rs1   = r_id_instr[19:15];
    assign w_rs2   = r_id_instr[24:20];
    assign w_imm_i = {{20{r_id_instr[31]}}, r_id_instr[31:20]};
    assign w_imm_s = {{20{r_id_instr[31]}}, r_id_instr[31:25], r_id_instr[11:7]};
    assign w_imm_u = {r_id_instr[31:12], 12'h0};

    // LUI/AUIPC/LW/SW all reuse the ALU add path (funct3 000) with chosen operands.
    always_comb begin
        w_we = 1'b0; w_ld = 1'b0; w_st = 1'b0; w_dec_f3 = 3'b000; w_alt = 1'b0;
        w_a_pc = 1'b0; w_a_zero = 1'b0; w_b_imm = 1'b1; w_imm = w_imm_i;
        w_use1 = 1'b0; w_use2 = 1'b0; w_dec_halt = 1'b0;
        case (w_op)
            7'h13: begin w_we = 1'b1; w_dec_f3 = w_f3; w_alt = (w_f3 == 3'b101) && r_id_instr[30]; w_use1 = 1'b1; end
            7'h33: begin w_we = 1'b1; w_dec_f3 = w_f3; w_alt = r_id_instr[30]; w_b_imm = 1'b0; w_use1 = 1'b1; w_use2 = 1'b1; end
            7'h37: begin w_we = 1'b1; w_a_zero = 1'b1; w_imm = w_imm_u; end
            7'h17: begin w_we = 1'b1; w_a_pc = 1'b1; w_imm = w_imm_u; end
            7'h03: if (w_f3 == 3'b010) begin w_we = 1'b1; w_ld = 1'b1; w_use1 = 1'b1; end
            7'h23: if (w_f3 == 3'b010) begin w_st = 1'b1; w_imm = w_imm_s; w_use1 = 1'b1; w_use2 = 1'b1; end
            7'h73: w_dec_halt = 1'b1;
            default: ;
        endcase
        // x0 writes are dropped here so forwarding never sees them.
        if (w_rd == 5'd0) w_we = 1'b0;
    end

    assign w_stall = r_ex_ld && r_ex_we &&
                     ((w_use1 && w_rs1 == r_ex_rd) || (w_use2 && w_rs2 == r_ex_rd));

    rv32_regfile u_regfile (
        .i_clk (i_clk),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (r_wb_we),
        .i_wa  (r_wb_rd),
        .i_wd  (r_wb_res)
    );

    // ---------------- EX: forwarding and ALU ----------------
    logic [31:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu;

    assign w_fwd_a = (r_mem_we && r_mem_rd == r_ex_rs1) ? r_mem_res :
                     (r_wb_we  && r_wb_rd  == r_ex_rs1) ? r_wb_res  : r_ex_a;
    assign w_fwd_b = (r_mem_we && r_mem_rd == r_ex_rs2) ? r_mem_res :
                     (r_wb_we  && r_wb_rd  == r_ex_rs2) ? r_wb_res  : r_ex_b;
    assign w_op_a  = r_ex_a_zero ? 32'h0 : r_ex_a_pc ? r_ex_pc : w_fwd_a;
    assign w_op_b  = r_ex_b_imm ? r_ex_imm : w_fwd_b;

    always_comb begin
        w_alu = 32'h0;
        case (r_ex_f3)
            3'b000: w_alu = r_ex_alt ? (w_op_a - w_op_b) : (w_op_a + w_op_b);
            3'b001: w_alu = w_op_a << w_op_b[4:0];
            3'b010: w_alu = {31'h0, $signed(w_op_a) < $signed(w_op_b)};
            3'b011: w_alu = {31'h0, w_op_a < w_op_b};
            3'b100: w_alu = w_op_a ^ w_op_b;
            3'b101: w_alu = r_ex_alt ? 32'($signed(w_op_a) >>> w_op_b[4:0]) : (w_op_a >> w_op_b[4:0]);
            3'b110: w_alu = w_op_a | w_op_b;
            3'b111: w_alu = w_op_a & w_op_b;
            default: ;
        endcase
    end

    // ---------------- MEM ----------------
    assign o_rom_addr  = if_pc;
    assign o_ram_addr  = r_mem_res;
    assign o_ram_wdata = r_mem_sd;
    assign o_ram_ce    = r_mem_ld | r_mem_st;
    assign o_ram_we    = r_mem_st;
    assign o_ram_sel   = {4{r_mem_ld | r_mem_st}};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            if_pc <= 32'h0; r_halt <= 1'b0;
            r_id_instr <= NOP; r_id_pc <= 32'h0;
            r_ex_pc <= 32'h0; r_ex_a <= 32'h0; r_ex_b <= 32'h0; r_ex_imm <= 32'h0;
            r_ex_rs1 <= 5'd0; r_ex_rs2 <= 5'd0; r_ex_rd <= 5'd0; r_ex_f3 <= 3'b000;
            r_ex_alt <= 1'b0; r_ex_a_pc <= 1'b0; r_ex_a_zero <= 1'b0; r_ex_b_imm <= 1'b1;
            r_ex_we <= 1'b0; r_ex_ld <= 1'b0; r_ex_st <= 1'b0;
            r_mem_res <= 32'h0; r_mem_sd <= 32'h0; r_mem_rd <= 5'd0;
            r_mem_we <= 1'b0; r_mem_ld <= 1'b0; r_mem_st <= 1'b0;
            r_wb_res <= 32'h0; r_wb_rd <= 5'd0; r_wb_we <= 1'b0;
        end else begin
            // IF: once a halt is seen in ID the PC freezes and only NOPs enter ID.
            if (!w_stall) begin
                if (r_halt || w_dec_halt) begin
                    r_halt     <= 1'b1;
                    r_id_instr <= NOP;
                end else begin
                    if_pc      <= {20'h0, if_pc[11:0] + 12'd4};
                    r_id_instr <= i_rom_data;
                    r_id_pc    <= if_pc;
                end
            end
            // ID/EX: load-use stall sends a bubble and holds IF/ID.
            r_ex_pc <= r_id_pc; r_ex_a <= w_rd1; r_ex_b <= w_rd2; r_ex_imm <= w_imm;
            r_ex_rs1 <= w_rs1; r_ex_rs2 <= w_rs2; r_ex_rd <= w_rd; r_ex_f3 <= w_dec_f3;
            r_ex_alt <= w_alt; r_ex_a_pc <= w_a_pc; r_ex_a_zero <= w_a_zero; r_ex_b_imm <= w_b_imm;
            r_ex_we <= w_we && !w_stall; r_ex_ld <= w_ld && !w_stall; r_ex_st <= w_st && !w_stall;
            // EX/MEM
            r_mem_res <= w_alu; r_mem_sd <= w_fwd_b; r_mem_rd <= r_ex_rd;
            r_mem_we <= r_ex_we; r_mem_ld <= r_ex_ld; r_mem_st <= r_ex_st;
            // MEM/WB
            r_wb_res <= r_mem_ld ? i_ram_rdata : r_mem_res;
            r_wb_rd  <= r_mem_rd;
            r_wb_we  <= r_mem_we;
        end
    end
endmodule

module rv32_soc_top (
    input logic clk,
    input logic rst_n
);
    logic [31:0] rom_addr, rom_data, ram_addr, ram_data, core_ram_data;
    logic [3:0]  ram_sel;
    logic        ram_ce, ram_we;

    rv32_rom u_rom (
        .i_addr (rom_addr[11:2]),
        .o_data (rom_data)
    );

    rv32_ram u_ram (
        .i_clk   (clk),
        .i_ce    (ram_ce),
        .i_we    (ram_we),
        .i_sel   (ram_sel),
        .i_addr  (ram_addr[12:2]),
        .i_wdata (core_ram_data),
        .o_rdata (ram_data)
    );

    rv32_core u_core_top (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (core_ram_data),
        .i_ram_rdata (ram_data),
        .o_ram_sel   (ram_sel),
        .o_ram_ce    (ram_ce),
        .o_ram_we    (ram_we)
    );
endmodule

// File: tb/tb_rv32_soc_top.sv
// tb/tb_rv32_soc_top.sv - directed self-checking bench for rv32_soc_top
module tb_rv32_soc_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    rv32_soc_top dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] rf(input int idx);
        return dut.u_core_top.u_regfile.regfile[idx];
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 1024; i++) dut.u_rom.rom_mem[i] = 32'h0000_0073;
        for (int i = 0; i < 32; i++) dut.u_core_top.u_regfile.regfile[i] = 32'h0;
        for (int i = 0; i < 8; i++) dut.u_ram.ram_mem[i] = 32'h0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after the last reset edge (cycle 0 of the program).
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        wait_cycles(2);
        check({tag, "_pc"}, dut.u_core_top.if_pc, 32'h0);
        check({tag, "_ram_ce"}, {31'h0, dut.ram_ce}, 32'h0);
        check({tag, "_ram_we"}, {31'h0, dut.ram_we}, 32'h0);
        rst_n = 1'b1;
    endtask

    logic [31:0] w_pc_hold;
    int          n_changes;

    initial begin
        // ---------------- I-type chain and halt ----------------
        @(negedge clk);
        clear_all();
        dut.u_rom.rom_mem[0] = enc_i(12'd50,  5'd0, 3'b000, 5'd1);
        dut.u_rom.rom_mem[1] = enc_i(12'h814, 5'd1, 3'b000, 5'd2);
        dut.u_rom.rom_mem[2] = enc_i(12'h814, 5'd1, 3'b010, 5'd3);
        dut.u_rom.rom_mem[3] = enc_i(12'h814, 5'd1, 3'b011, 5'd4);
        dut.u_rom.rom_mem[4] = enc_i(12'h814, 5'd1, 3'b100, 5'd5);
        dut.u_rom.rom_mem[5] = enc_i(12'h814, 5'd1, 3'b110, 5'd6);
        dut.u_rom.rom_mem[6] = enc_i(12'h814, 5'd1, 3'b111, 5'd7);
        dut.u_rom.rom_mem[7] = enc_i(12'h003, 5'd2, 3'b001, 5'd8);
        dut.u_rom.rom_mem[8] = enc_i(12'h003, 5'd2, 3'b101, 5'd9);
        dut.u_rom.rom_mem[9] = enc_i(12'h403, 5'd2, 3'b101, 5'd10);
        do_reset("rst0");
        wait_cycles(4);
        check("x1_before_wb", rf(1), 32'h0);
        wait_cycles(1);
        check("x1_latency5", rf(1), 32'd50);
        wait_cycles(10);
        check("x10_by_15", rf(10), 32'hFFFF_FF08);
        wait_cycles(10);
        check("addi_x2",  rf(2),  32'hFFFF_F846);
        check("slti_x3",  rf(3),  32'h0);
        check("sltiu_x4", rf(4),  32'h1);
        check("xori_x5",  rf(5),  32'hFFFF_F826);
        check("ori_x6",   rf(6),  32'hFFFF_F836);
        check("andi_x7",  rf(7),  32'h0000_0010);
        check("slli_x8",  rf(8),  32'hFFFF_C230);
        check("srli_x9",  rf(9),  32'h1FFF_FF08);
        check("srai_x10", rf(10), 32'hFFFF_FF08);
        check("halt_pc", dut.u_core_top.if_pc, 32'd44);
        w_pc_hold = dut.u_core_top.if_pc;
        n_changes = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dut.u_core_top.if_pc !== w_pc_hold) n_changes++;
            for (int r = 11; r < 32; r++) if (rf(r) !== 32'h0) n_changes++;
        end
        check("halt_50_cycles_changes", n_changes, 32'h0);
        check("halt_x10_kept", rf(10), 32'hFFFF_FF08);

        // ---------------- R-type forwarding ----------------
        clear_all();
        dut.u_rom.rom_mem[0]  = enc_i(12'd7,   5'd0, 3'b000, 5'd1);
        dut.u_rom.rom_mem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2);
        dut.u_rom.rom_mem[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
        dut.u_rom.rom_mem[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd4);
        dut.u_rom.rom_mem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd5);
        dut.u_rom.rom_mem[5]  = enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd6);
        dut.u_rom.rom_mem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd7);
        dut.u_rom.rom_mem[7]  = enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd8);
        dut.u_rom.rom_mem[8]  = enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd9);
        dut.u_rom.rom_mem[9]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd10);
        dut.u_rom.rom_mem[10] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd11);
        dut.u_rom.rom_mem[11] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd12);
        dut.u_rom.rom_mem[12] = {20'h00001, 5'd13, 7'h17};
        do_reset("rst1");
        wait_cycles(25);
        check("sub_x3",   rf(3),  32'd10);
        check("sra_x4",   rf(4),  32'hFFFF_FFFF);
        check("sltu_x5",  rf(5),  32'h1);
        check("add_x6",   rf(6),  32'd20);
        check("xor_x7",   rf(7),  32'hFFFF_FFFA);
        check("srl_x8",   rf(8),  32'h01FF_FFFF);
        check("sll_x9",   rf(9),  32'h0000_0380);
        check("slt_x10",  rf(10), 32'h1);
        check("or_x11",   rf(11), 32'hFFFF_FFFF);
        check("and_x12",  rf(12), 32'h5);
        check("auipc_x13", rf(13), 32'h0000_1030);

        // ---------------- store, load and load-use stall ----------------
        clear_all();
        dut.u_rom.rom_mem[0] = {20'h12345, 5'd1, 7'h37};
        dut.u_rom.rom_mem[1] = enc_i(12'h678, 5'd1, 3'b000, 5'd1);
        dut.u_rom.rom_mem[2] = {7'd0, 5'd1, 5'd0, 3'b010, 5'd16, 7'h23};
        dut.u_rom.rom_mem[3] = {12'd16, 5'd0, 3'b010, 5'd2, 7'h03};
        dut.u_rom.rom_mem[4] = enc_i(12'd1, 5'd2, 3'b000, 5'd3);
        do_reset("rst2");
        wait_cycles(5);
        check("sw_ram_we",   {31'h0, dut.ram_we}, 32'h1);
        check("sw_ram_addr", dut.ram_addr, 32'd16);
        check("sw_wdata",    dut.core_ram_data, 32'h1234_5678);
        check("sw_sel",      {28'h0, dut.ram_sel}, 32'hF);
        wait_cycles(1);
        check("lw_ram_ce",   {31'h0, dut.ram_ce}, 32'h1);
        check("lw_ram_we",   {31'h0, dut.ram_we}, 32'h0);
        check("lw_ram_data", dut.ram_data, 32'h1234_5678);
        check("ram_word4",   dut.u_ram.ram_mem[4], 32'h1234_5678);
        wait_cycles(3);
        check("x3_stall_not_yet", rf(3), 32'h0);
        wait_cycles(1);
        check("x3_after_stall", rf(3), 32'h1234_5679);
        check("lw_x2", rf(2), 32'h1234_5678);

        // ---------------- x0 and mid-program reset ----------------
        clear_all();
        dut.u_rom.rom_mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1);
        dut.u_rom.rom_mem[1] = enc_i(12'd5, 5'd0, 3'b000, 5'd0);
        dut.u_rom.rom_mem[2] = enc_i(12'd9, 5'd0, 3'b000, 5'd3);
        dut.u_rom.rom_mem[3] = enc_i(12'd2, 5'd1, 3'b000, 5'd2);
        do_reset("rst3");
        wait_cycles(3);
        rst_n = 1'b0;
        wait_cycles(1);
        check("midrst_pc", dut.u_core_top.if_pc, 32'h0);
        rst_n = 1'b1;
        wait_cycles(1);
        check("midrst_no_retire_x1", rf(1), 32'h0);
        wait_cycles(20);
        check("rerun_x1", rf(1), 32'd1);
        check("x0_kept",  rf(0), 32'h0);
        check("x0_read",  rf(3), 32'd9);
        check("rerun_x2", rf(2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
